// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and shared-memory signals between the pipeline, the arbiter and memory.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, bus_err
    );
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports, data first with a
// streak limit so fetch is not starved, and a timeout that completes a hung access with bus_err.
module mem_arbiter #(
    parameter int DM_STREAK = 4,
    parameter int TIMEOUT   = 15
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;
    state_t        state, state_nxt;
    logic [2:0]    streak;
    logic [TW-1:0] tmo;
    logic [31:0]   lat_addr, lat_wdata, if_rdata, dm_rdata;
    logic          lat_we, owner_dm, err;
    logic          busy, grant_dm, grant_if, expired, if_ack, dm_ack;
    assign busy     = state == BUSY_IF || state == BUSY_DM;
    assign grant_dm = state == IDLE && bus.dm_req && !(streak == 3'(DM_STREAK) && bus.if_req);
    assign grant_if = state == IDLE && bus.if_req && !grant_dm;
    // last allowed BUSY cycle; mem_ready in this cycle still wins
    assign expired  = tmo == TW'(TIMEOUT - 1);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:             state_nxt = grant_dm ? BUSY_DM : grant_if ? BUSY_IF : IDLE;
            BUSY_IF, BUSY_DM: state_nxt = (bus.mem_ready || expired) ? RESP : state;
            default:          state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak    <= '0;
            tmo       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            owner_dm  <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if (grant_dm || grant_if) begin
                lat_addr  <= grant_dm ? bus.dm_addr : bus.if_addr;
                lat_wdata <= grant_dm ? bus.dm_wdata : '0;
                lat_we    <= grant_dm && bus.dm_we;
                owner_dm  <= grant_dm;
                tmo       <= '0;
                streak    <= (grant_dm && bus.if_req) ? streak + 3'd1 : '0;
            end
            if (busy) begin
                err <= !bus.mem_ready;
                if (!bus.mem_ready) tmo <= tmo + TW'(1);
                if (bus.mem_ready && owner_dm && !lat_we) dm_rdata <= bus.mem_rdata;
                if (bus.mem_ready && !owner_dm) if_rdata <= bus.mem_rdata;
            end
        end
    end
    assign if_ack        = state == RESP && !owner_dm;
    assign dm_ack        = state == RESP && owner_dm;
    assign bus.if_ack    = if_ack;
    assign bus.dm_ack    = dm_ack;
    assign bus.bus_err   = state == RESP && err;
    assign bus.if_rdata  = if_rdata;
    assign bus.dm_rdata  = dm_rdata;
    assign bus.mem_en    = busy;
    assign bus.mem_we    = state == BUSY_DM && lat_we;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.stall_if  = bus.if_req && !if_ack;
    assign bus.stall_mem = bus.dm_req && !dm_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration order, latency, starvation limit, timeout and reset abort.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   busy;
    logic ack_seen;
    mem_arbiter_if b();
    mem_arbiter #(.DM_STREAK(4), .TIMEOUT(15)) dut (.clk(clk), .reset(reset), .bus(b.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask
    task automatic wait_en();
        for (int i = 0; i < 20 && b.mem_en !== 1'b1; i++) @(negedge clk);
        check("en_wait", 32'(b.mem_en), 32'd1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1);
    end
    initial begin
        b.if_req = 0; b.if_addr = 0; b.dm_req = 0; b.dm_we = 0;
        b.dm_addr = 0; b.dm_wdata = 0; b.mem_rdata = 0; b.mem_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_mem_en", 32'({b.mem_en, b.mem_we}), 32'd0);
        check("rst_acks", 32'({b.if_ack, b.dm_ack, b.bus_err}), 32'd0);
        check("rst_if_rdata", b.if_rdata, 32'd0);
        check("rst_dm_rdata", b.dm_rdata, 32'd0);
        check("rst_streak", 32'(dut.streak), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        // stray mem_ready in IDLE
        b.mem_ready = 1; b.mem_rdata = 32'h77;
        @(negedge clk);
        check("idle_ready_ack", 32'({b.if_ack, b.dm_ack, b.mem_en}), 32'd0);
        check("idle_ready_rdata", b.if_rdata, 32'd0);
        b.mem_ready = 0;
        // single fetch, mem_ready two cycles after mem_en
        b.if_req = 1; b.if_addr = 32'h100;
        #1 check("t1_stall_if_req", 32'(b.stall_if), 32'd1);
        check("t1_idle_en", 32'(b.mem_en), 32'd0);
        @(negedge clk);
        check("t1_mem_en", 32'(b.mem_en), 32'd1);
        check("t1_mem_addr", b.mem_addr, 32'h100);
        check("t1_mem_we", 32'(b.mem_we), 32'd0);
        @(negedge clk);
        check("t1_stall_wait", 32'(b.stall_if), 32'd1);
        @(negedge clk);
        b.mem_ready = 1; b.mem_rdata = 32'hDEADBEEF;
        #1 check("t1_no_early_ack", 32'(b.if_ack), 32'd0);
        @(negedge clk);
        check("t1_if_ack", 32'(b.if_ack), 32'd1);
        check("t1_if_rdata", b.if_rdata, 32'hDEADBEEF);
        check("t1_stall_off", 32'(b.stall_if), 32'd0);
        check("t1_resp_en", 32'({b.mem_en, b.bus_err, b.dm_ack}), 32'd0);
        b.if_req = 0; b.mem_ready = 0;
        @(negedge clk);
        check("t1_ack_pulse", 32'(b.if_ack), 32'd0);
        check("t1_rdata_hold", b.if_rdata, 32'hDEADBEEF);
        // simultaneous requests: data store wins
        b.if_req = 1; b.if_addr = 32'h200;
        b.dm_req = 1; b.dm_we = 1; b.dm_addr = 32'h40; b.dm_wdata = 32'h5; b.mem_rdata = 32'h12345678;
        @(negedge clk);
        check("t2_dm_addr", b.mem_addr, 32'h40);
        check("t2_mem_we", 32'(b.mem_we), 32'd1);
        check("t2_mem_wdata", b.mem_wdata, 32'h5);
        check("t2_stall_mem", 32'(b.stall_mem), 32'd1);
        b.mem_ready = 1;
        @(negedge clk);
        check("t2_acks", 32'({b.dm_ack, b.if_ack, b.bus_err}), 32'b100);
        check("t2_store_rdata", b.dm_rdata, 32'd0);
        b.mem_ready = 0; b.dm_req = 0; b.dm_we = 0;
        @(negedge clk);
        check("t2_idle_en", 32'(b.mem_en), 32'd0);
        @(negedge clk);
        check("t2_if_grant", 32'({b.mem_en, b.mem_we}), 32'b10);
        check("t2_if_addr", b.mem_addr, 32'h200);
        b.mem_ready = 1; b.mem_rdata = 32'hCAFE0001;
        @(negedge clk);
        check("t2_if_ack", 32'({b.dm_ack, b.if_ack}), 32'b01);
        check("t2_if_rdata", b.if_rdata, 32'hCAFE0001);
        b.if_req = 0; b.mem_ready = 0;
        @(negedge clk);
        check("t2_streak", 32'(dut.streak), 32'd0);
        // starvation: four data grants then fetch
        b.if_req = 1; b.if_addr = 32'h300; b.dm_req = 1; b.dm_we = 0; b.dm_addr = 32'h80;
        for (int t = 0; t < 5; t++) begin
            wait_en();
            check($sformatf("t3_addr%0d", t), b.mem_addr, t < 4 ? 32'h80 : 32'h300);
            b.mem_ready = 1; b.mem_rdata = 32'hA0 + 32'(t);
            @(negedge clk);
            check($sformatf("t3_ack%0d", t), 32'({b.dm_ack, b.if_ack}), t < 4 ? 32'b10 : 32'b01);
            b.mem_ready = 0;
            @(negedge clk);
        end
        check("t3_streak", 32'(dut.streak), 32'd0);
        check("t3_dm_rdata", b.dm_rdata, 32'hA3);
        check("t3_if_rdata", b.if_rdata, 32'hA4);
        b.if_req = 0; b.dm_req = 0;
        @(negedge clk);
        // timeout: load never completed
        b.dm_req = 1; b.dm_addr = 32'h90; b.mem_rdata = 32'hBAD;
        busy = 0;
        for (int i = 0; i < 40 && b.dm_ack !== 1'b1; i++) begin
            @(negedge clk);
            if (b.mem_en === 1'b1) busy++;
        end
        check("t4_busy_cycles", 32'(busy), 32'd15);
        check("t4_ack_err", 32'({b.dm_ack, b.bus_err}), 32'b11);
        check("t4_rdata_kept", b.dm_rdata, 32'hA3);
        b.dm_req = 0;
        @(negedge clk);
        check("t4_err_pulse", 32'({b.dm_ack, b.bus_err}), 32'd0);
        // mem_ready on the last allowed cycle is a normal completion
        b.dm_req = 1; b.dm_addr = 32'h94; b.mem_rdata = 32'h5EED;
        busy = 0;
        for (int i = 0; i < 40 && b.dm_ack !== 1'b1; i++) begin
            @(negedge clk);
            if (b.mem_en === 1'b1) busy++;
            if (b.mem_en === 1'b1 && busy == 15) b.mem_ready = 1;
        end
        check("t4b_busy_cycles", 32'(busy), 32'd15);
        check("t4b_ack_noerr", 32'({b.dm_ack, b.bus_err}), 32'b10);
        check("t4b_rdata", b.dm_rdata, 32'h5EED);
        b.mem_ready = 0; b.dm_req = 0;
        @(negedge clk);
        // reset during BUSY_IF
        b.if_req = 1; b.if_addr = 32'h500;
        wait_en();
        check("t5_addr", b.mem_addr, 32'h500);
        #2 reset = 1'b0;
        #1 check("t5_en_async", 32'(b.mem_en), 32'd0);
        check("t5_rdata_clr", b.if_rdata, 32'd0);
        b.mem_ready = 1; b.mem_rdata = 32'h99;
        ack_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (b.if_ack === 1'b1 || b.mem_en === 1'b1) ack_seen = 1;
        end
        check("t5_no_ack_in_reset", 32'(ack_seen), 32'd0);
        b.mem_ready = 0;
        reset = 1'b1;
        #1 check("t5_idle_after", 32'(dut.state), 32'd0);
        check("t5_no_early_grant", 32'(b.mem_en), 32'd0);
        @(negedge clk);
        check("t5_first_grant", 32'(b.mem_en), 32'd1);
        b.mem_ready = 1;
        @(negedge clk);
        check("t5_ack_after", 32'(b.if_ack), 32'd1);
        check("t5_rdata_after", b.if_rdata, 32'h99);
        b.mem_ready = 0; b.if_req = 0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose parameter DM_STREAK, default 4, the maximum number of consecutive data-port grants made while a fetch request is pending.
REQ-002 The block SHALL expose parameter TIMEOUT, default 15, the maximum number of BUSY cycles allowed without mem_ready.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  fetch (stage 1) read request, held until if_ack.
REQ-006 if_addr  in  32  fetch address, stable while if_req is high.
REQ-007 if_rdata  out  32  fetch read data, valid with if_ack, held until the next fetch response.
REQ-008 if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 dm_req  in  1  data (stage 4) request, held until dm_ack.
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_addr, dm_wdata  in  32 each  data address and store data, stable while dm_req is high.
REQ-012 dm_rdata  out  32  load data, valid with dm_ack, held until the next data response.
REQ-013 dm_ack  out  1  one-cycle data completion pulse.
REQ-014 mem_en, mem_we  out  1 each  shared single-port memory enable and write strobe.
REQ-015 mem_addr, mem_wdata  out  32 each  shared memory address and write data.
REQ-016 mem_rdata  in  32, mem_ready  in  1  memory read data and completion, sampled only in BUSY states.
REQ-017 stall_if, stall_mem  out  1 each  pipeline stall requests to the pipeline controller.
REQ-018 bus_err  out  1  asserted with an ack that ended by timeout.

Function
REQ-019 The FSM SHALL have the states IDLE, BUSY_IF, BUSY_DM and RESP.
REQ-020 In IDLE with dm_req=1, the FSM SHALL go to BUSY_DM unless the streak counter equals DM_STREAK and if_req=1, in which case it SHALL go to BUSY_IF.
REQ-021 In IDLE with only if_req=1, the FSM SHALL go to BUSY_IF; with no request it SHALL remain in IDLE.
REQ-022 On entry to a BUSY state, the request's address, wdata and we SHALL be latched into registers; mem_addr, mem_wdata and mem_we SHALL be driven from these latches.
REQ-023 mem_en SHALL be 1 in both BUSY states and 0 otherwise; mem_we SHALL be 1 only in BUSY_DM with the latched we=1.
REQ-024 In a BUSY state with mem_ready=1, the FSM SHALL capture mem_rdata into the owner's rdata register (loads and fetches only; a store leaves dm_rdata unchanged) and go to RESP.
REQ-025 In RESP, the FSM SHALL pulse the owner's ack for exactly one cycle, ignore all requests, and go to IDLE next.
REQ-026 Latency SHALL be: request seen in IDLE at cycle 0, mem_en=1 from cycle 1, mem_ready at cycle k, ack at k+1, IDLE at k+2.
REQ-027 A req still high in IDLE after its RESP SHALL be treated as a new request.
REQ-028 The streak counter SHALL be 3 bits wide and SHALL count as follows: +1 on each BUSY_DM grant made while if_req=1, cleared on every BUSY_IF grant, and cleared on any BUSY_DM grant made while if_req=0.
REQ-029 The timeout counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ready.
REQ-030 When the timeout counter reaches TIMEOUT, the FSM SHALL go to RESP with bus_err=1 alongside the ack and leave the owner's rdata unchanged.
REQ-031 mem_ready and the timeout reached in the same cycle SHALL count as a normal completion with bus_err=0.
REQ-032 stall_if SHALL equal if_req & ~if_ack, and stall_mem SHALL equal dm_req & ~dm_ack (combinational).
REQ-033 mem_ready outside a BUSY state SHALL be ignored.

Reset
REQ-034 While reset=0, the block SHALL asynchronously force: state=IDLE; streak counter, timeout counter and latches = 0; if_rdata=dm_rdata=0; if_ack=dm_ack=bus_err=0; mem_en=mem_we=0.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction with no ack; the first grant SHALL occur no earlier than the first clk edge after reset rises.

Verification
REQ-036 The bench SHALL cover a single fetch: if_req with if_addr=0x100 and mem_ready two cycles after mem_en with mem_rdata=0xDEADBEEF -> mem_addr=0x100, if_ack one cycle later, if_rdata=0xDEADBEEF, stall_if high until the ack.
REQ-037 The bench SHALL cover simultaneous requests: if_req and dm_req (store, addr 0x40, wdata 0x5) in the same cycle -> BUSY_DM first with mem_we=1, mem_wdata=0x5, then BUSY_IF after RESP and IDLE.
REQ-038 The bench SHALL cover starvation: dm_req held with if_req high for 5 transactions -> 4 data grants, then a fetch grant, then streak=0.
REQ-039 The bench SHALL cover timeout: a load with mem_ready never asserted -> dm_ack with bus_err=1 after 15 BUSY cycles, dm_rdata unchanged.
REQ-040 The bench SHALL cover reset mid-BUSY: reset=0 while in BUSY_IF -> mem_en=0 immediately, no if_ack, and IDLE after reset is released.
